trap_ctrl: RTL and testbench

Trap sequencing controller between the execute stage and the `csr` block. It arbitrates synchronous exceptions (illegal instruction, ecall), `mret`, and the external and timer interrupts. It drives the CSR trap-update inputs for exactly one cycle, then issues a pipeline flush with the redirect PC taken from `mtvec` or `mepc`. It stalls the pipeline for the whole sequence.

---
 rtl/trap_ctrl.sv | 130 +++++++++++++
 tb/tb_trap_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: trap sequencing controller between EX and the csr block.
// Arbitrates illegal/ecall/mret and external/timer interrupts, presents the
// trap code to csr for one cycle, then flushes the pipeline and redirects
// to mtvec (traps) or mepc (mret). Stalls the pipeline for the whole sequence.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   inst_valid_i, inst_addr_i  EX instruction present / its PC
//   illegal_i, ecall_i, mret_i synchronous events (qualified by inst_valid_i)
//   ext_irq_i, timer_irq_i     level interrupt requests
//   mstatus_i, mie_i,
//   mtvec_i, mepc_i            current CSR values
//   excepttype_o               trap code to csr (0 = none)
//   current_inst_addr_o        trapping PC to csr
//   stall_o, flush_o, new_pc_o pipeline control and redirect target
module trap_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        illegal_i,
  input  logic        ecall_i,
  input  logic        mret_i,
  input  logic        ext_irq_i,
  input  logic        timer_irq_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  typedef enum logic [2:0] {
    IDLE,
    TRAP_CSR,
    TRAP_JUMP,
    MRET_CSR,
    MRET_JUMP
  } state_t;

  state_t      state;
  logic [31:0] cause_q;   // cause kept past the CSR cycle for vectoring
  logic        ev_trap;
  logic        ev_mret;
  logic [31:0] ev_code;
  logic [31:0] tvec_base;

  // Event detection, priority order; only sampled in IDLE.
  always_comb begin
    ev_trap = 1'b0;
    ev_mret = 1'b0;
    ev_code = '0;
    if (state == IDLE && inst_valid_i) begin
      if (illegal_i) begin
        ev_trap = 1'b1;
        ev_code = 32'h0000_0002;
      end else if (ecall_i) begin
        ev_trap = 1'b1;
        ev_code = 32'h0000_000b;
      end else if (mret_i) begin
        ev_mret = 1'b1;
        ev_code = 32'h0000_000a;
      end else if (ext_irq_i && mstatus_i[3] && mie_i[11]) begin
        ev_trap = 1'b1;
        ev_code = 32'h8000_000b;
      end else if (timer_irq_i && mstatus_i[3] && mie_i[7]) begin
        ev_trap = 1'b1;
        ev_code = 32'h8000_0007;
      end
    end
  end

  assign stall_o = (state != IDLE) || ev_trap || ev_mret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      cause_q             <= '0;
      flush_o             <= 1'b0;
    end else begin
      excepttype_o        <= '0;
      current_inst_addr_o <= '0;
      flush_o             <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_trap || ev_mret) begin
            state               <= ev_trap ? TRAP_CSR : MRET_CSR;
            excepttype_o        <= ev_code;
            current_inst_addr_o <= inst_addr_i;
            cause_q             <= ev_code;
          end
        end
        TRAP_CSR: begin
          state   <= TRAP_JUMP;
          flush_o <= 1'b1;
        end
        MRET_CSR: begin
          state   <= MRET_JUMP;
          flush_o <= 1'b1;
        end
        TRAP_JUMP, MRET_JUMP: state <= IDLE;
        default:              state <= IDLE;
      endcase
    end
  end

  // Target is formed combinationally in the JUMP cycle so that mret sees
  // the mepc value csr committed at the end of MRET_CSR.
  assign tvec_base = {mtvec_i[31:2], 2'b00};

  always_comb begin
    new_pc_o = '0;
    case (state)
      TRAP_JUMP: begin
        if (mtvec_i[1:0] == 2'b01 && cause_q[31])
          new_pc_o = tvec_base + {26'd0, cause_q[3:0], 2'b00};
        else
          new_pc_o = tvec_base;
      end
      MRET_JUMP: new_pc_o = mepc_i;
      default:   new_pc_o = '0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic [31:0] inst_addr_i;
  logic        illegal_i, ecall_i, mret_i, ext_irq_i, timer_irq_i;
  logic [31:0] mstatus_i, mie_i, mtvec_i, mepc_i;
  logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
  logic        stall_o, flush_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  trap_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .inst_valid_i        (inst_valid_i),
    .inst_addr_i         (inst_addr_i),
    .illegal_i           (illegal_i),
    .ecall_i             (ecall_i),
    .mret_i              (mret_i),
    .ext_irq_i           (ext_irq_i),
    .timer_irq_i         (timer_irq_i),
    .mstatus_i           (mstatus_i),
    .mie_i               (mie_i),
    .mtvec_i             (mtvec_i),
    .mepc_i              (mepc_i),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .stall_o             (stall_o),
    .flush_o             (flush_o),
    .new_pc_o            (new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    inst_valid_i = 1'b0;
    illegal_i    = 1'b0;
    ecall_i      = 1'b0;
    mret_i       = 1'b0;
    ext_irq_i    = 1'b0;
    timer_irq_i  = 1'b0;
  endtask

  initial begin
    clear_ev();
    inst_addr_i = '0;
    mstatus_i   = 32'h8;
    mie_i       = '0;
    mtvec_i     = 32'h80;
    mepc_i      = '0;
    rst         = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_exc",   excepttype_o,        32'h0);
    chk("rst_addr",  current_inst_addr_o, 32'h0);
    chk("rst_pc",    new_pc_o,            32'h0);
    chk("rst_flush", {31'd0, flush_o},    32'h0);
    chk("rst_stall", {31'd0, stall_o},    32'h0);

    // Illegal at 0x100, mtvec 0x80
    inst_valid_i = 1'b1; illegal_i = 1'b1; inst_addr_i = 32'h100;
    #1 chk("ill_N_stall", {31'd0, stall_o}, 32'h1);
    tick(); clear_ev(); #1;
    chk("ill_N1_exc",   excepttype_o,        32'h2);
    chk("ill_N1_addr",  current_inst_addr_o, 32'h100);
    chk("ill_N1_stall", {31'd0, stall_o},    32'h1);
    chk("ill_N1_flush", {31'd0, flush_o},    32'h0);
    tick();
    chk("ill_N2_flush", {31'd0, flush_o},    32'h1);
    chk("ill_N2_pc",    new_pc_o,            32'h80);
    chk("ill_N2_exc",   excepttype_o,        32'h0);
    chk("ill_N2_stall", {31'd0, stall_o},    32'h1);
    tick();
    chk("ill_N3_stall", {31'd0, stall_o},    32'h0);
    chk("ill_N3_flush", {31'd0, flush_o},    32'h0);

    // Invalid instruction: illegal not qualified
    illegal_i = 1'b1; inst_valid_i = 1'b0;
    #1 chk("inv_stall", {31'd0, stall_o}, 32'h0);
    tick(); clear_ev(); #1;
    chk("inv_exc", excepttype_o, 32'h0);

    // External interrupt, vectored mtvec 0x41
    mie_i = 32'h800; mtvec_i = 32'h41;
    inst_valid_i = 1'b1; ext_irq_i = 1'b1; inst_addr_i = 32'h300;
    #1 chk("ext_N_stall", {31'd0, stall_o}, 32'h1);
    tick(); clear_ev(); #1;
    chk("ext_exc",  excepttype_o,        32'h8000000b);
    chk("ext_addr", current_inst_addr_o, 32'h300);
    tick();
    chk("ext_flush", {31'd0, flush_o}, 32'h1);
    chk("ext_pc",    new_pc_o,         32'h6c);
    tick();
    chk("ext_N3_stall", {31'd0, stall_o}, 32'h0);

    // Same with global MIE clear: nothing happens
    mstatus_i = 32'h0;
    inst_valid_i = 1'b1; ext_irq_i = 1'b1;
    #1 chk("extdis_stall", {31'd0, stall_o}, 32'h0);
    tick(); #1;
    chk("extdis_exc",    excepttype_o,     32'h0);
    chk("extdis_stall2", {31'd0, stall_o}, 32'h0);
    tick();
    chk("extdis_flush",  {31'd0, flush_o}, 32'h0);
    clear_ev();
    mstatus_i = 32'h8;

    // Ecall + timer together; mtvec still vectored, ecall uses base
    mie_i = 32'h80;
    inst_valid_i = 1'b1; ecall_i = 1'b1; timer_irq_i = 1'b1; inst_addr_i = 32'h400;
    #1 chk("ecall_N_stall", {31'd0, stall_o}, 32'h1);
    tick(); inst_valid_i = 1'b0; ecall_i = 1'b0; #1;
    chk("ecall_exc", excepttype_o, 32'hb);
    tick();
    chk("ecall_pc",    new_pc_o,         32'h40);
    chk("ecall_flush", {31'd0, flush_o}, 32'h1);
    tick();
    chk("ecall_N3_stall", {31'd0, stall_o}, 32'h0);
    inst_valid_i = 1'b1; inst_addr_i = 32'h404;
    #1 chk("tmr_N_stall", {31'd0, stall_o}, 32'h1);
    tick(); clear_ev(); #1;
    chk("tmr_exc",  excepttype_o,        32'h80000007);
    chk("tmr_addr", current_inst_addr_o, 32'h404);
    tick();
    chk("tmr_pc", new_pc_o, 32'h5c);
    tick();

    // mret; csr updates mepc at end of MRET_CSR
    mtvec_i = 32'h80; mepc_i = 32'h1fc;
    inst_valid_i = 1'b1; mret_i = 1'b1; inst_addr_i = 32'h500;
    #1 chk("mret_N_stall", {31'd0, stall_o}, 32'h1);
    tick(); clear_ev(); #1;
    chk("mret_exc", excepttype_o, 32'ha);
    chk("mret_flush_early", {31'd0, flush_o}, 32'h0);
    @(posedge clk); mepc_i = 32'h204; #1;
    chk("mret_flush", {31'd0, flush_o}, 32'h1);
    chk("mret_pc",    new_pc_o,         32'h204);
    tick();
    chk("mret_N3_flush", {31'd0, flush_o}, 32'h0);
    chk("mret_N3_stall", {31'd0, stall_o}, 32'h0);

    // ecall beats mret on the same instruction
    inst_valid_i = 1'b1; ecall_i = 1'b1; mret_i = 1'b1; inst_addr_i = 32'h600;
    tick(); clear_ev(); #1;
    chk("prio_exc", excepttype_o, 32'hb);
    tick();
    chk("prio_pc", new_pc_o, 32'h80);
    tick();

    // Reset in TRAP_CSR aborts the sequence
    inst_valid_i = 1'b1; illegal_i = 1'b1; inst_addr_i = 32'h700;
    tick(); clear_ev(); rst = 1'b1; #1;
    chk("rstmid_csr_exc", excepttype_o, 32'h2);
    tick(); rst = 1'b0; #1;
    chk("rstmid_exc",   excepttype_o,        32'h0);
    chk("rstmid_addr",  current_inst_addr_o, 32'h0);
    chk("rstmid_flush", {31'd0, flush_o},    32'h0);
    chk("rstmid_stall", {31'd0, stall_o},    32'h0);
    chk("rstmid_pc",    new_pc_o,            32'h0);
    tick();
    chk("rstmid_noflush", {31'd0, flush_o}, 32'h0);

    // Back-to-back: instruction held during sequence, re-accepted at N+3
    inst_valid_i = 1'b1; illegal_i = 1'b1; inst_addr_i = 32'h800;
    tick(); inst_addr_i = 32'h804; #1;
    chk("b2b_csr_exc",  excepttype_o,        32'h2);
    chk("b2b_csr_addr", current_inst_addr_o, 32'h800);
    tick();
    chk("b2b_jump_flush", {31'd0, flush_o}, 32'h1);
    chk("b2b_jump_exc",   excepttype_o,     32'h0);
    tick();
    chk("b2b_N3_stall", {31'd0, stall_o},    32'h1);
    chk("b2b_N3_exc",   excepttype_o,        32'h0);
    tick(); clear_ev(); #1;
    chk("b2b_re_exc",  excepttype_o,        32'h2);
    chk("b2b_re_addr", current_inst_addr_o, 32'h804);
    tick();
    chk("b2b_re_flush", {31'd0, flush_o}, 32'h1);
    tick();
    chk("b2b_end_stall", {31'd0, stall_o}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
